// File: rtl/pmod_audio_i2s_tx.sv
// pmod_audio_i2s_tx
// I2S transmitter for the Pmod I2S2 DAC (CS4344). Stereo 24-bit samples
// arrive on a valid/ready stream and are buffered in a small FIFO. MCLK,
// SCLK and LRCK are derived from ACLK. One sample is serialised per frame.
// A frame that starts with an empty FIFO sends silence and raises a sticky
// underrun flag.
//
// Ports:
//   ACLK, ARESETN    sole clock; asynchronous active-low reset
//   s_tdata          [47:24] left, [23:0] right, two's complement
//   s_tvalid/ready   sample stream; ready is low when full or in reset
//   enable           runs the clock generator and serialiser
//   underrun_clr     one-cycle pulse that clears underrun (and its count)
//   mclk/lrck/sclk   DAC clocks; lrck low selects the left channel
//   sdout            serial data, changes on SCLK falling edges
//   fifo_level       current FIFO occupancy
//   underrun         sticky empty-FIFO-at-frame-boundary flag
//   underrun_count   saturating underrun counter, present only when the
//                    macro PMOD_AUDIO_UNDERRUN_CNT_EN is defined
module pmod_audio_i2s_tx #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [47:0]                   s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          enable,
    input  logic                          underrun_clr,
    output logic                          mclk,
    output logic                          lrck,
    output logic                          sclk,
    output logic                          sdout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
`ifdef PMOD_AUDIO_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [AW:0]   LEVEL_MAX = (AW + 1)'(FIFO_DEPTH);

    logic [DW-1:0] div_q, div_d;
    logic [8:0]    phase_q, phase_d;
    logic          mclk_q, mclk_d;
    logic          sclk_q, sclk_d;
    logic          lrck_q, lrck_d;
    logic          sdout_q, sdout_d;
    logic [47:0]   shadow_q, shadow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          underrun_q, underrun_d;
    logic [47:0]   mem_q [FIFO_DEPTH];

    logic          full;
    logic          push;
    logic          step;
    logic          boundary;
    logic          pop;
    logic          starve;
    logic [4:0]    slot;
    logic [4:0]    bit_idx;
    logic [23:0]   word;

    // The level only reflects last cycle's push, so a push landing on the
    // boundary cycle is invisible to that frame's pop and counts as starve.
    assign full     = (level_q == LEVEL_MAX);
    assign s_tready = ~full & ARESETN;
    assign push     = s_tvalid & s_tready;
    assign step     = enable && (div_q == DIV_LAST);
    assign boundary = step && (phase_q == 9'd511);
    assign pop      = boundary && (level_q != '0);
    assign starve   = boundary && (level_q == '0);

    // Divider, phase counter and the clock outputs derived from the next
    // phase, so the registered clocks always equal the phase register bits.
    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        if (!enable) begin
            div_d   = '0;
            phase_d = '0;
        end else if (step) begin
            div_d   = '0;
            phase_d = phase_q + 9'd1;
        end else begin
            div_d   = div_q + 1'b1;
        end
        mclk_d = phase_d[0];
        sclk_d = phase_d[2];
        lrck_d = phase_d[8];
    end

    // Serial data changes only as phase[2:0] enters 0 (SCLK falling edge).
    // Slot 0 is the I2S one-bit delay; slots 1..24 carry MSB first. The
    // shadow is only reloaded at slot 0, where the output is 0 anyway.
    always_comb begin
        sdout_d = sdout_q;
        slot    = phase_d[7:3];
        bit_idx = 5'd24 - slot;
        word    = phase_d[8] ? shadow_q[23:0] : shadow_q[47:24];
        if (!enable) begin
            sdout_d = 1'b0;
        end else if (step && (phase_d[2:0] == 3'd0)) begin
            if ((slot >= 5'd1) && (slot <= 5'd24)) begin
                sdout_d = word[bit_idx];
            end else begin
                sdout_d = 1'b0;
            end
        end
    end

    // FIFO bookkeeping and the per-frame shadow register load.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        shadow_d   = shadow_q;
        underrun_d = underrun_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            shadow_d = mem_q[rd_ptr_q];
        end else if (starve) begin
            shadow_d = '0;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // A new underrun wins over a coincident clear.
        if (starve) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            div_q      <= '0;
            phase_q    <= '0;
            mclk_q     <= 1'b0;
            sclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            sdout_q    <= 1'b0;
            shadow_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            phase_q    <= phase_d;
            mclk_q     <= mclk_d;
            sclk_q     <= sclk_d;
            lrck_q     <= lrck_d;
            sdout_q    <= sdout_d;
            shadow_q   <= shadow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers/level.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_tdata;
        end
    end

`ifdef PMOD_AUDIO_UNDERRUN_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Clear and increment together leave a count of exactly one.
    always_comb begin
        cnt_d = cnt_q;
        if (underrun_clr) begin
            cnt_d = starve ? 16'd1 : 16'd0;
        end else if (starve && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign underrun_count = cnt_q;
`endif

    assign mclk       = mclk_q;
    assign sclk       = sclk_q;
    assign lrck       = lrck_q;
    assign sdout      = sdout_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_pmod_audio_i2s_tx.sv
// Testbench for pmod_audio_i2s_tx: directed sequence covering reset, underrun,
// clock ratios, serial data content (scoreboard of expected bits), FIFO full
// back-pressure, mid-frame reset and the clear/underrun collision.
module tb_pmod_audio_i2s_tx;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [47:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        enable;
    logic        underrun_clr;
    logic        mclk, lrck, sclk, sdout;
    logic [4:0]  fifo_level;
    logic        underrun;
`ifdef PMOD_AUDIO_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    int checks = 0;
    int errors = 0;
    logic expq[$];

    pmod_audio_i2s_tx #(.CLK_DIV(4), .FIFO_DEPTH(16)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .enable        (enable),
        .underrun_clr  (underrun_clr),
        .mclk          (mclk),
        .lrck          (lrck),
        .sclk          (sclk),
        .sdout         (sdout),
        .fifo_level    (fifo_level),
        .underrun      (underrun)
`ifdef PMOD_AUDIO_UNDERRUN_CNT_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    always #5 ACLK = ~ACLK;

    task automatic applyStimulus(input logic en, input logic valid,
                                 input logic [47:0] data, input logic clr);
        enable       = en;
        s_tvalid     = valid;
        s_tdata      = data;
        underrun_clr = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [47:0] observed,
                               input logic [47:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected serial stream for one frame: slot 0 delay, 24 data bits MSB
    // first, 7 padding zeros; left half then right half.
    task automatic pushExpected(input logic [47:0] sample);
        logic [23:0] l, r;
        l = sample[47:24];
        r = sample[23:0];
        for (int k = 0; k < 32; k++) expq.push_back((k >= 1 && k <= 24) ? l[24-k] : 1'b0);
        for (int k = 0; k < 32; k++) expq.push_back((k >= 1 && k <= 24) ? r[24-k] : 1'b0);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int first_ur, ones, misalign, bits, acc, found;
        int m_last, m_prev, s_last, s_prev, l_last, l_prev;
        logic pm, ps, pl;
        logic [15:0] cnt_at;
        logic [47:0] s1, s2;

        ARESETN = 1'b0;
        applyStimulus(1'b0, 1'b0, 48'h0, 1'b0);
        #1;
        checkOutput("rst_tready_low", 48'(s_tready), 48'h0);
        repeat (3) @(negedge ACLK);
        checkOutput("rst_outputs", 48'({mclk, lrck, sclk, sdout, underrun}), 48'h0);
        checkOutput("rst_level", 48'(fifo_level), 48'h0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        checkOutput("rel_tready", 48'(s_tready), 48'h1);

        // Empty FIFO with enable: silence and an underrun at the first wrap.
        applyStimulus(1'b1, 1'b0, 48'h0, 1'b0);
        first_ur = -1; ones = 0; cnt_at = 16'hFFFF;
        for (int i = 1; i <= 4096; i++) begin
            @(negedge ACLK);
            if (sdout) ones++;
            if (underrun && first_ur < 0) begin
                first_ur = i;
`ifdef PMOD_AUDIO_UNDERRUN_CNT_EN
                cnt_at = underrun_count;
`endif
            end
        end
        checkOutput("ur_first_cycle", 48'(first_ur), 48'd2048);
        checkOutput("ur_sdout_silent", 48'(ones), 48'd0);
`ifdef PMOD_AUDIO_UNDERRUN_CNT_EN
        checkOutput("ur_count_first", 48'(cnt_at), 48'd1);
`endif
        applyStimulus(1'b1, 1'b0, 48'h0, 1'b1);
        @(negedge ACLK);
        applyStimulus(1'b1, 1'b0, 48'h0, 1'b0);
        checkOutput("ur_cleared", 48'(underrun), 48'h0);

        // Clock periods and edge alignment.
        pm = mclk; ps = sclk; pl = lrck; misalign = 0;
        m_last = -1; m_prev = -1; s_last = -1; s_prev = -1; l_last = -1; l_prev = -1;
        for (int j = 0; j < 4200; j++) begin
            @(negedge ACLK);
            if (mclk && !pm) begin m_prev = m_last; m_last = j; end
            if (sclk && !ps) begin s_prev = s_last; s_last = j; end
            if (lrck && !pl) begin l_prev = l_last; l_last = j; end
            if ((sclk != ps || lrck != pl) && mclk == pm) misalign++;
            pm = mclk; ps = sclk; pl = lrck;
        end
        checkOutput("mclk_period", 48'(m_last - m_prev), 48'd8);
        checkOutput("sclk_period", 48'(s_last - s_prev), 48'd32);
        checkOutput("lrck_period", 48'(l_last - l_prev), 48'd2048);
        checkOutput("edge_align", 48'(misalign), 48'd0);

        applyStimulus(1'b0, 1'b0, 48'h0, 1'b1);
        @(negedge ACLK);
        applyStimulus(1'b0, 1'b0, 48'h0, 1'b0);
        checkOutput("disabled_outs", 48'({mclk, lrck, sclk, sdout}), 48'h0);
        checkOutput("disabled_ur_clr", 48'(underrun), 48'h0);

        // Two samples queued while disabled; frames 2 and 3 carry them.
        s1 = 48'hABCDEF_123456;
        s2 = 48'h800001_7FFFFE;
        applyStimulus(1'b0, 1'b1, s1, 1'b0);
        pushExpected(s1);
        @(negedge ACLK);
        applyStimulus(1'b0, 1'b1, s2, 1'b0);
        pushExpected(s2);
        @(negedge ACLK);
        applyStimulus(1'b0, 1'b0, 48'h0, 1'b0);
        checkOutput("level_two", 48'(fifo_level), 48'd2);
        applyStimulus(1'b1, 1'b0, 48'h0, 1'b0);
        found = -1; pl = lrck;
        for (int i = 1; i <= 2200; i++) begin
            @(negedge ACLK);
            if (pl && !lrck) begin found = i; break; end
            pl = lrck;
        end
        checkOutput("first_pop_cycle", 48'(found), 48'd2048);
        checkOutput("pop_no_underrun", 48'(underrun), 48'h0);
        checkOutput("pop_level", 48'(fifo_level), 48'd1);
        bits = 0; ps = sclk;
        for (int i = 0; i < 4300 && bits < 128; i++) begin
            @(negedge ACLK);
            if (sclk && !ps && expq.size() > 0) begin
                checkOutput($sformatf("sd_bit%0d", bits), 48'(sdout), 48'(expq.pop_front()));
                bits++;
            end
            ps = sclk;
        end
        checkOutput("sd_bits_seen", 48'(bits), 48'd128);
        applyStimulus(1'b0, 1'b0, 48'h0, 1'b0);
        @(negedge ACLK);

        // Fill while disabled, then the 17th waits for a boundary pop.
        applyStimulus(1'b0, 1'b1, 48'h5A5A5A_A5A5A5, 1'b0);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_tready) acc++;
            @(negedge ACLK);
        end
        checkOutput("fill_accepted", 48'(acc), 48'd16);
        checkOutput("fill_level", 48'(fifo_level), 48'd16);
        checkOutput("fill_tready", 48'(s_tready), 48'h0);
        applyStimulus(1'b1, 1'b1, 48'h5A5A5A_A5A5A5, 1'b0);
        found = -1;
        for (int i = 1; i <= 2200; i++) begin
            @(negedge ACLK);
            if (s_tready) begin found = i; break; end
        end
        checkOutput("stall_release_cycle", 48'(found), 48'd2048);
        @(negedge ACLK);
        applyStimulus(1'b1, 1'b0, 48'h0, 1'b0);
        checkOutput("refill_level", 48'(fifo_level), 48'd16);
        checkOutput("refill_tready", 48'(s_tready), 48'h0);

        // Mid-frame reset with five entries queued.
        ARESETN = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        applyStimulus(1'b1, 1'b1, 48'h111111_222222, 1'b0);
        repeat (5) @(negedge ACLK);
        applyStimulus(1'b1, 1'b0, 48'h0, 1'b0);
        repeat (600) @(negedge ACLK);
        checkOutput("five_level", 48'(fifo_level), 48'd5);
        ARESETN = 1'b0;
        #1;
        checkOutput("midrst_outs", 48'({mclk, lrck, sclk, sdout, underrun}), 48'h0);
        checkOutput("midrst_level", 48'(fifo_level), 48'd0);
        checkOutput("midrst_tready", 48'(s_tready), 48'h0);
        repeat (3) @(negedge ACLK);
        checkOutput("midrst_hold", 48'({mclk, lrck, sclk, sdout, fifo_level}), 48'h0);
        applyStimulus(1'b0, 1'b0, 48'h0, 1'b0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        checkOutput("midrst_rel_tready", 48'(s_tready), 48'h1);

        // Clear coinciding with an empty-FIFO boundary keeps the flag.
        applyStimulus(1'b1, 1'b0, 48'h0, 1'b0);
        repeat (2047) @(negedge ACLK);
        applyStimulus(1'b1, 1'b0, 48'h0, 1'b1);
        @(negedge ACLK);
        applyStimulus(1'b1, 1'b0, 48'h0, 1'b0);
        checkOutput("clr_coincide_flag", 48'(underrun), 48'h1);
`ifdef PMOD_AUDIO_UNDERRUN_CNT_EN
        checkOutput("clr_coincide_count", 48'(underrun_count), 48'd1);
`endif
        repeat (10) @(negedge ACLK);
        applyStimulus(1'b1, 1'b0, 48'h0, 1'b1);
        @(negedge ACLK);
        applyStimulus(1'b1, 1'b0, 48'h0, 1'b0);
        checkOutput("clr_later_flag", 48'(underrun), 48'h0);
`ifdef PMOD_AUDIO_UNDERRUN_CNT_EN
        checkOutput("clr_later_count", 48'(underrun_count), 48'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
